// File: rtl/wb_periph_bridge.sv
// Registered Wishbone bridge: decodes a 3-bit slot, forwards one transaction to the
// selected peripheral and turns unmapped or hung accesses into an error-word ack.
module wb_periph_bridge #(
   parameter int                 NSLV     = 5,
   parameter logic [3*NSLV-1:0]  SLOT_MAP = {3'b101, 3'b100, 3'b010, 3'b001, 3'b000},
   parameter int                 SLOT_LSB = 17,
   parameter int                 TIMEOUT  = 255,
   parameter logic [31:0]        ERR_DAT  = 32'hDEADBEEF
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_i,
   input  logic                 wbs_cyc_i,
   input  logic                 wbs_stb_i,
   input  logic                 wbs_we_i,
   input  logic [3:0]           wbs_sel_i,
   input  logic [31:0]          wbs_adr_i,
   input  logic [31:0]          wbs_dat_i,
   output logic                 wbs_ack_o,
   output logic [31:0]          wbs_dat_o,
   output logic [NSLV-1:0]      s_cyc_o,
   output logic [NSLV-1:0]      s_stb_o,
   output logic                 s_we_o,
   output logic [3:0]           s_sel_o,
   output logic [31:0]          s_adr_o,
   output logic [31:0]          s_dat_o,
   input  logic [NSLV-1:0]      s_ack_i,
   input  logic [32*NSLV-1:0]   s_dat_i,
   input  logic                 err_clr_i,
   output logic                 err_irq_o,
   output logic [1:0]           err_code_o,
   output logic [31:0]          err_adr_o
);

   typedef enum logic [1:0] {IDLE, FWD, RESP, ERR} state_t;

   state_t            state, state_n;
   logic [NSLV-1:0]   strb;
   logic [NSLV-1:0]   hit_vec;
   logic              hit, load, ack_sel, set_err;
   logic [1:0]        err_kind;
   logic [2:0]        slot;
   logic [31:0]       rd_dat;
   logic [15:0]       cnt;

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) state <= IDLE;
      else          state <= state_n;
   end

   always_comb begin
      state_n  = state;
      hit_vec  = '0;
      load     = 1'b0;
      set_err  = 1'b0;
      err_kind = 2'b00;
      rd_dat   = '0;
      slot     = wbs_adr_i[SLOT_LSB+2:SLOT_LSB];
      for (int i = 0; i < NSLV; i++) begin
         if (slot == SLOT_MAP[3*i +: 3]) hit_vec[i] = 1'b1;
         if (strb[i]) rd_dat = rd_dat | s_dat_i[32*i +: 32];
      end
      hit     = |hit_vec;
      ack_sel = |(s_ack_i & strb);
      case (state)
         IDLE: if (wbs_cyc_i && wbs_stb_i) begin
            load    = 1'b1;
            state_n = hit ? FWD : ERR;
            if (!hit) begin
               set_err  = 1'b1;
               err_kind = 2'b01;
            end
         end
         // Master abort outranks ack; ack outranks timeout.
         FWD: if (!wbs_cyc_i)  state_n = IDLE;
              else if (ack_sel) state_n = RESP;
              else if (cnt == 16'(TIMEOUT - 1)) begin
                 state_n  = ERR;
                 set_err  = 1'b1;
                 err_kind = 2'b10;
              end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         strb       <= '0;
         s_we_o     <= 1'b0;
         s_sel_o    <= '0;
         s_adr_o    <= '0;
         s_dat_o    <= '0;
         wbs_dat_o  <= '0;
         cnt        <= '0;
         err_irq_o  <= 1'b0;
         err_code_o <= 2'b00;
         err_adr_o  <= '0;
      end else begin
         if (load) begin
            s_adr_o <= wbs_adr_i;
            s_dat_o <= wbs_dat_i;
            s_sel_o <= wbs_sel_i;
            s_we_o  <= wbs_we_i;
            strb    <= hit_vec;
            cnt     <= '0;
         end
         if (state == FWD) begin
            cnt <= cnt + 16'd1;
            if (state_n != FWD) strb <= '0;
            if (state_n == RESP) wbs_dat_o <= rd_dat;
         end
         // A new error beats a simultaneous clear.
         if (set_err) begin
            wbs_dat_o  <= ERR_DAT;
            err_irq_o  <= 1'b1;
            err_code_o <= err_kind;
            err_adr_o  <= (state == IDLE) ? wbs_adr_i : s_adr_o;
         end else if (err_clr_i) begin
            err_irq_o  <= 1'b0;
            err_code_o <= 2'b00;
         end
      end
   end

   assign s_cyc_o   = strb;
   assign s_stb_o   = strb;
   assign wbs_ack_o = (state == RESP) || (state == ERR);

endmodule

// File: doc/wb_periph_bridge.md
Name: wb_periph_bridge

Overview:
- Registered Wishbone bridge between the Caravel management-side Wishbone port and the user-area peripherals (timer, UART, PSRAM controller, DAC, ADC).
- Decodes a 3-bit address slot, forwards one transaction at a time to the selected slave, and returns its data and ack.
- Answers unmapped addresses and hung slaves with an error word, so the management core never stalls.
- Sits directly upstream of the peripheral instances; replaces the purely combinational steering in the user wrapper.

Parameters:
- NSLV, 5, number of downstream slaves.
- SLOT_MAP, {3'b101,3'b100,3'b010,3'b001,3'b000}, packed 3-bit slot codes; slave i owns code SLOT_MAP[3i+2:3i]. Codes must be unique.
- SLOT_LSB, 17, LSB of the slot field; the field is wbs_adr_i[SLOT_LSB+2:SLOT_LSB].
- TIMEOUT, 255, cycles to wait for a slave ack (1..65535).
- ERR_DAT, 32'hDEADBEEF, read data returned on error.

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  asynchronous reset, active-high
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  master cycle, strobe, write enable
- wbs_sel_i  in  4  master byte selects
- wbs_adr_i, wbs_dat_i  in  32 each  master address, write data
- wbs_ack_o  out  1  ack to master
- wbs_dat_o  out  32  read data to master
- s_cyc_o, s_stb_o  out  NSLV each  per-slave cycle and strobe, one-hot or zero
- s_we_o  out  1  shared write enable
- s_sel_o  out  4  shared byte selects
- s_adr_o, s_dat_o  out  32 each  shared address, write data
- s_ack_i  in  NSLV  per-slave acks
- s_dat_i  in  32*NSLV  per-slave read data; slave i uses bits [32i+31:32i]
- err_clr_i  in  1  clears err_irq_o and err_code_o
- err_irq_o  out  1  sticky error flag
- err_code_o  out  2  00 none, 01 unmapped, 10 timeout
- err_adr_o  out  32  address of the most recent error

Behaviour:
- Reset values: all outputs 0, state IDLE, timeout counter 0.
- The FSM has four states: IDLE, FWD, RESP, ERR.
- IDLE:
  - On wbs_cyc_i & wbs_stb_i, latch adr, dat, sel and we into the s_* outputs.
  - Match the slot field against SLOT_MAP.
  - Hit on slave k: next cycle assert s_cyc_o[k] and s_stb_o[k]; go to FWD; clear the counter.
  - Miss: go to ERR.
- FWD:
  - The counter increments every cycle.
  - If s_ack_i[k]: capture s_dat_i[k] into wbs_dat_o, drop s_cyc_o and s_stb_o, go to RESP.
  - Else if counter == TIMEOUT-1: drop the strobes, go to ERR with code 10.
  - Ack and timeout in the same cycle: ack wins.
  - Acks from non-selected slaves are ignored.
- RESP: wbs_ack_o = 1 for exactly one cycle, then return to IDLE.
- ERR:
  - wbs_dat_o = ERR_DAT and wbs_ack_o = 1 for one cycle; go to IDLE.
  - err_irq_o <= 1; err_code_o is set to 01 (unmapped) or 10 (timeout); err_adr_o <= latched address.
  - Writes also ack; the data is dropped.
- Latency:
  - Zero-wait slave (acks the cycle s_stb_o is high): master ack 3 cycles after stb sampled in IDLE.
  - Unmapped address: master ack 2 cycles after stb sampled.
- Master abort: wbs_cyc_i low while in FWD drops the slave strobes, returns to IDLE with no ack, and leaves no error.
- Back-to-back: stb still high in the IDLE cycle after an ack is treated as a new transaction.
- wbs_ack_o is 0 in every cycle except RESP and ERR; wbs_dat_o holds its value between transactions.
- Error register updates:
  - err_clr_i clears err_irq_o and err_code_o; err_adr_o is kept.
  - err_clr_i in the same cycle as a new error: the error wins (set).
  - A second error overwrites err_code_o and err_adr_o.
- Reset mid-transaction: all strobes and the ack drop immediately (asynchronous); state returns to IDLE.
- Width rules: the counter is 16 bits; the comparison uses TIMEOUT-1, so TIMEOUT=1 means a slave must ack in the first FWD cycle.

Test Plan:
1. Read 0x30020004, UART (slot 001, k=1) acks after 2 cycles with 0x12345678:
   - Only s_stb_o[1] high, for 2 cycles.
   - wbs_ack_o pulses once; wbs_dat_o = 0x12345678; no error.
2. Write 0x300A0000 with data 0xA5, sel 0001; ADC acks at once:
   - s_dat_o = 0xA5, s_sel_o = 0001, s_we_o = 1.
   - Master ack 3 cycles after stb.
3. Read 0x30060000 (slot 011, unmapped):
   - Ack after 2 cycles; wbs_dat_o = 0xDEADBEEF.
   - err_irq_o = 1, err_code_o = 01, err_adr_o = 0x30060000.
4. Read to the timer, which never acks, with TIMEOUT=8:
   - s_stb_o[0] high for 8 cycles, then ERR.
   - Data 0xDEADBEEF; err_code_o = 10.
   - Then pulse err_clr_i: irq and code return to 0.
5. Master drops cyc 1 cycle into FWD on PSRAM:
   - Slave strobes low next cycle; no wbs_ack_o; err_irq_o stays 0.
6. Assert wb_rst_i while in FWD:
   - s_stb_o, wbs_ack_o and err_irq_o go to 0 immediately.
   - After release, a normal read completes.
